if_prefetch_unit: RTL

//  Parametrised instruction-fetch stage with a decoupled prefetch FIFO. It runs ahead of decode,

---
 rtl/if_prefetch_unit.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/if_prefetch_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : if_prefetch_unit                                              |
// | Description : Instruction-fetch stage with a decoupled prefetch FIFO and an |
// |               IF/ID output register. Optional macro: IF_BYPASS_EN.          |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module if_prefetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               flush,
    input  logic               Branch_taken,
    input  logic [ADDR_W-1:0]  BranchAddr,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0]  PC,
    output logic [INSTR_W-1:0] Instruction,
    output logic               valid
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    typedef enum logic [1:0] {
        c_IDLE = 2'd0,
        c_REQ  = 2'd1,
        c_WAIT = 2'd2,
        c_DROP = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [ADDR_W-1:0]    r_fetch_pc;
    logic [ADDR_W-1:0]    r_req_addr;
    logic [ADDR_W-1:0]    r_fifo_pc    [DEPTH];
    logic [INSTR_W-1:0]   r_fifo_instr [DEPTH];
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic [ADDR_W-1:0]    r_pc;
    logic [INSTR_W-1:0]   r_instr;
    logic                 r_valid;

    logic w_accept;
    logic w_resp;
    logic w_empty;
    logic w_load;
    logic w_pop;
    logic w_push;
    logic w_bypass;

    assign w_accept = (r_state == c_REQ) && imem_ready;
    // A response that arrives together with a redirect is stale and is dropped.
    assign w_resp   = (r_state == c_WAIT) && imem_rvalid && !Branch_taken;
    assign w_empty  = (r_count == '0);
    assign w_load   = !Branch_taken && !flush && !freeze;
    assign w_pop    = w_load && !w_empty;

`ifdef IF_BYPASS_EN
    assign w_bypass = w_load && w_empty && w_resp;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push      = w_resp && !w_bypass;
    assign imem_req    = (r_state == c_REQ);
    assign imem_addr   = r_fetch_pc;
    assign PC          = r_pc;
    assign Instruction = r_instr;
    assign valid       = r_valid;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            // Issue only when a FIFO slot is free, so the response can never overflow it.
            c_IDLE: if (r_count < c_CNT_W'(DEPTH)) w_next_state = c_REQ;
            c_REQ:  if (imem_ready) w_next_state = Branch_taken ? c_DROP : c_WAIT;
            c_WAIT: begin
                if (imem_rvalid)       w_next_state = c_IDLE;
                else if (Branch_taken) w_next_state = c_DROP;
            end
            c_DROP: if (imem_rvalid) w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= c_IDLE;
            r_fetch_pc <= RESET_PC;
            r_req_addr <= '0;
        end else begin
            r_state <= w_next_state;
            if (Branch_taken)  r_fetch_pc <= BranchAddr;
            else if (w_accept) r_fetch_pc <= r_fetch_pc + PC_STEP;
            if (w_accept) r_req_addr <= r_fetch_pc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (Branch_taken) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]    <= r_req_addr;
            r_fifo_instr[r_wr_ptr] <= imem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_instr <= '0;
        end else if (Branch_taken || flush) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_instr <= '0;
        end else if (!freeze) begin
            if (!w_empty) begin
                r_valid <= 1'b1;
                r_pc    <= r_fifo_pc[r_rd_ptr];
                r_instr <= r_fifo_instr[r_rd_ptr];
            end else if (w_bypass) begin
                r_valid <= 1'b1;
                r_pc    <= r_req_addr;
                r_instr <= imem_rdata;
            end else begin
                r_valid <= 1'b0;
                r_pc    <= '0;
                r_instr <= '0;
            end
        end
    end

endmodule
`default_nettype wire
